// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared CPU widths, load/store opcodes, FSM states and lane helpers.
package mem_access_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'hEB;

    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic [RegBus-1:0]     ZeroWord   = '0;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    function automatic logic is_load(input logic [AluOpBus-1:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic logic is_store(input logic [AluOpBus-1:0] op);
        return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
    endfunction

    function automatic logic is_byte(input logic [AluOpBus-1:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP;
    endfunction

    function automatic logic is_half(input logic [AluOpBus-1:0] op);
        return op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP;
    endfunction

    function automatic logic misaligned(input logic [AluOpBus-1:0] op, input logic [1:0] a);
        return (is_half(op) && a[0]) || ((op == EXE_LW_OP || op == EXE_SW_OP) && a != 2'b00);
    endfunction

    function automatic logic [3:0] lane_sel(input logic [AluOpBus-1:0] op, input logic [1:0] a);
        return is_byte(op) ? 4'b0001 << a : is_half(op) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [RegBus-1:0] store_data(input logic [AluOpBus-1:0] op, input logic [RegBus-1:0] d);
        return is_byte(op) ? {4{d[7:0]}} : is_half(op) ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// mem_load_align: picks the addressed lane(s) from a read word and sign/zero-extends.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [RegBus-1:0]   rdata,
    input  logic [1:0]          addr,
    input  logic [AluOpBus-1:0] aluop,
    output logic [RegBus-1:0]   value
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        value = aluop == EXE_LB_OP  ? {{24{b[7]}}, b} :
                aluop == EXE_LBU_OP ? {24'h0, b} :
                aluop == EXE_LH_OP  ? {{16{h[15]}}, h} :
                aluop == EXE_LHU_OP ? {16'h0, h} : rdata;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage with a stalling IDLE/BUSY/DONE data-bus handshake.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [AluOpBus-1:0]   ex_aluop,
    input  logic [RegBus-1:0]     ex_mem_addr,
    input  logic [RegBus-1:0]     ex_reg2,
    input  logic                  flush,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [RegBus-1:0]     dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [RegBus-1:0]     dbus_wdata,
    input  logic [RegBus-1:0]     dbus_rdata,
    input  logic                  dbus_ack,
    output logic [RegAddrBus-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  stallreq,
    output logic                  excpt_misalign
);
    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, flush_q, flush_d;
    logic [RegBus-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, load_val;
    logic [3:0]        sel_q, sel_d;
    logic              is_mem;

    mem_load_align u_align (
        .rdata (dbus_rdata),
        .addr  (ex_mem_addr[1:0]),
        .aluop (ex_aluop),
        .value (load_val)
    );

    always_comb begin
        state_d = state_q;
        req_d = req_q;
        we_d = we_q;
        addr_d = addr_q;
        sel_d = sel_q;
        wdata_d = wdata_q;
        data_d = data_q;
        flush_d = flush_q;
        mem_wd = ex_wd;
        mem_wreg = ex_wreg;
        mem_wdata = ex_wdata;
        stallreq = 1'b0;
        excpt_misalign = 1'b0;
        is_mem = is_load(ex_aluop) || is_store(ex_aluop);
        if (state_q == IDLE) begin
            if (flush) begin
                mem_wreg = 1'b0;
            end else if (is_mem && misaligned(ex_aluop, ex_mem_addr[1:0])) begin
                mem_wreg = 1'b0;
                excpt_misalign = 1'b1;
            end else if (is_mem) begin
                mem_wreg = 1'b0;
                stallreq = 1'b1;
                req_d = 1'b1;
                we_d = is_store(ex_aluop);
                addr_d = {ex_mem_addr[31:2], 2'b00};
                sel_d = lane_sel(ex_aluop, ex_mem_addr[1:0]);
                wdata_d = store_data(ex_aluop, ex_reg2);
                state_d = BUSY;
            end
        end else if (state_q == BUSY) begin
            mem_wreg = 1'b0;
            stallreq = 1'b1;
            flush_d = flush_q || flush;
            if (dbus_ack) begin
                req_d = 1'b0;
                data_d = load_val;
                state_d = DONE;
            end
        end else begin
            // upstream is still stalled, so ex_* still describes the completing instruction
            mem_wdata = data_q;
            mem_wreg = is_load(ex_aluop) && !flush_q && !flush && ex_wreg;
            flush_d = 1'b0;
            state_d = IDLE;
        end
        if (!rst) begin
            mem_wd = NOPRegAddr;
            mem_wreg = 1'b0;
            mem_wdata = ZeroWord;
            stallreq = 1'b0;
            excpt_misalign = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= ZeroWord;
            sel_q <= 4'b0000;
            wdata_q <= ZeroWord;
            data_q <= ZeroWord;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            we_q <= we_d;
            addr_q <= addr_d;
            sel_q <= sel_d;
            wdata_q <= wdata_d;
            data_q <= data_d;
            flush_q <= flush_d;
        end
    end

    assign dbus_req = req_q;
    assign dbus_we = we_q;
    assign dbus_addr = addr_q;
    assign dbus_sel = sel_q;
    assign dbus_wdata = wdata_q;
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  single pipeline clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 ex_wd  in  5  destination register address from EX/MEM.
REQ-004 ex_wreg  in  1  destination write enable from EX/MEM.
REQ-005 ex_wdata  in  32  ALU result for non-memory ops.
REQ-006 ex_aluop  in  8  operation code (LB, LBU, LH, LHU, LW, SB, SH, SW; anything else = non-memory).
REQ-007 ex_mem_addr  in  32  effective byte address.
REQ-008 ex_reg2  in  32  store data.
REQ-009 flush  in  1  discard the current instruction's result.
REQ-010 dbus_req, dbus_we  out  1 each  data-bus request and write strobe, registered.
REQ-011 dbus_addr  out  32  word address {addr[31:2],2'b00}, registered.
REQ-012 dbus_sel  out  4  byte lanes, registered; dbus_wdata  out  32  lane-replicated store data, registered.
REQ-013 dbus_rdata  in  32; dbus_ack  in  1  transfer complete.
REQ-014 mem_wd  out  5; mem_wreg  out  1; mem_wdata  out  32  to the MEM/WB register.
REQ-015 stallreq  out  1  hold all upstream stages and MEM/WB.
REQ-016 excpt_misalign  out  1  misaligned access flag.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 Non-memory op in IDLE SHALL pass ex_wd/ex_wreg/ex_wdata combinationally to mem_* with stallreq=0.
REQ-019 Aligned memory op in IDLE SHALL drive stallreq=1 and mem_wreg=0, load dbus_* registers, set dbus_req=1, and go to BUSY.
REQ-020 BUSY SHALL hold every dbus_* output stable with stallreq=1 and mem_wreg=0 until dbus_ack=1, then clear dbus_req, capture the aligned load result, and go to DONE.
REQ-021 dbus_ack SHALL be ignored outside BUSY; ack in the first BUSY cycle is legal, so the minimum memory-op occupancy is 3 cycles.
REQ-022 DONE SHALL drive stallreq=0 and present the captured result (loads: mem_wreg=ex_wreg; stores: mem_wreg=0), then return to IDLE.
REQ-023 Byte order is little-endian: byte lane n = addr[1:0]==n, bits 8n+7:8n; halfword lanes 0011 (addr[1]=0) or 1100; word lanes 1111.
REQ-024 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-025 SB SHALL replicate ex_reg2[7:0] to all four lanes and SH SHALL replicate ex_reg2[15:0] to both halves.
REQ-026 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no bus access and SHALL drive mem_wreg=0, stallreq=0, excpt_misalign=1 for that cycle only.
REQ-027 flush in IDLE SHALL force mem_wreg=0 and block any bus request.
REQ-028 flush in BUSY SHALL NOT abort the transfer; the FSM SHALL wait for ack and the result SHALL be discarded (mem_wreg=0 in DONE).
REQ-029 A flush in BUSY SHALL be latched until DONE, even if it is deasserted earlier.
REQ-030 excpt_misalign and stallreq SHALL be 0 whenever flush=1 in IDLE.

Reset
REQ-031 While rst=0: state=IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, captured data=0, latched flush=0.
REQ-032 While rst=0: mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0, excpt_misalign=0.
REQ-033 Reset asserted in BUSY SHALL abandon the transfer immediately; the bus slave is reset by the same signal.

Structure
REQ-034 The shared CPU defines package SHALL hold the RegBus(32)/RegAddrBus(5)/AluOpBus(8) widths, the load/store aluop codes, NOPRegAddr, ZeroWord and the FSM state encodings.
REQ-035 Load lane extraction and extension SHALL be a combinational sub-module, mem_load_align (inputs rdata, addr[1:0], aluop; output 32-bit value).

Verification
REQ-036 LW addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF -> dbus_sel=1111; stallreq high 3 cycles; mem_wdata=0xDEADBEEF with mem_wreg=1 in DONE.
REQ-037 LB addr 0x103 with rdata 0x80xxxxxx -> mem_wdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 SH addr 0x202, ex_reg2=0x1234ABCD -> dbus_we=1, dbus_sel=1100, dbus_wdata=0xABCDABCD; mem_wreg=0 in DONE.
REQ-039 LW addr 0x101 -> no dbus_req, excpt_misalign=1 for one cycle, stallreq=0, mem_wreg=0.
REQ-040 LW with flush pulsed in BUSY, ack 4 cycles later -> dbus_req held until ack; mem_wreg=0 in DONE.
REQ-041 Add op (ex_wd=5, ex_wdata=7) directly after a store's DONE cycle -> passes through in the same cycle with stallreq=0.
